// File: rtl/sad_sequencer_if.sv
// SAD unit command bus: address pair plus window/frame configuration and opcode.
interface sad_sequencer_if;
  logic [31:0] MemAddress;
  logic [31:0] WindowAddress;
  logic [31:0] Width;
  logic [31:0] Height;
  logic [5:0]  ALUOp;
  logic        SADOp;

  modport master (
    output MemAddress, WindowAddress, Width, Height, ALUOp, SADOp
  );

  modport slave (
    input MemAddress, WindowAddress, Width, Height, ALUOp, SADOp
  );
endinterface

// File: rtl/sad_sequencer.sv
// SAD command sequencer: programs window and frame sizes, then walks every
// window pixel row by row, issuing one frame/window address pair per beat.
module sad_sequencer #(
  parameter logic [31:0] ADDR_STEP   = 32'd4,
  parameter logic [5:0]  OP_IDLE     = 6'b000000,
  parameter logic [5:0]  OP_SETWIN   = 6'b111110,
  parameter logic [5:0]  OP_SETFRAME = 6'b111100,
  parameter logic [5:0]  OP_SAD      = 6'b111111
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic                   hold,
  input  logic [31:0]            frame_base,
  input  logic [31:0]            window_base,
  input  logic [31:0]            win_w,
  input  logic [31:0]            win_h,
  input  logic [31:0]            frame_w,
  sad_sequencer_if.master        cmd,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CFG_WIN   = 3'd1;
  localparam logic [2:0] S_CFG_FRAME = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] win_w_q, win_w_d, win_h_q, win_h_d, frame_w_q, frame_w_d;
  logic [31:0] frame_base_q, frame_base_d, window_base_q, window_base_d;
  logic [31:0] col_q, col_d, row_q, row_d;
  logic [31:0] mem_addr_q, mem_addr_d, win_addr_q, win_addr_d;
  logic [31:0] width_q, width_d, height_q, height_d;
  logic [5:0]  aluop_q, aluop_d;
  logic        sadop_q, sadop_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic        last_col, last_row;
  logic [31:0] row_jump;

  assign last_col = (col_q == win_w_q - 32'd1);
  assign last_row = (row_q == win_h_q - 32'd1);
  // Constant-step product; folds to a shift for power-of-two strides.
  assign row_jump = (frame_w_q - win_w_q + 32'd1) * ADDR_STEP;

  // Next-state and registered-output computation; outputs reflect the state being entered.
  always_comb begin
    state_d       = state_q;
    win_w_d       = win_w_q;
    win_h_d       = win_h_q;
    frame_w_d     = frame_w_q;
    frame_base_d  = frame_base_q;
    window_base_d = window_base_q;
    col_d         = col_q;
    row_d         = row_q;
    mem_addr_d    = mem_addr_q;
    win_addr_d    = win_addr_q;
    width_d       = width_q;
    height_d      = height_q;
    aluop_d       = aluop_q;
    sadop_d       = sadop_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        sadop_d = 1'b0;
        aluop_d = OP_IDLE;
        if (start) begin
          win_w_d       = win_w;
          win_h_d       = win_h;
          frame_w_d     = frame_w;
          frame_base_d  = frame_base;
          window_base_d = window_base;
          busy_d        = 1'b1;
          if (win_w == 32'd0 || win_h == 32'd0) begin
            // Empty window: skip configuration entirely and flag it.
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = S_CFG_WIN;
            aluop_d  = OP_SETWIN;
            width_d  = win_w;
            height_d = win_h;
            sadop_d  = 1'b1;
          end
        end
      end
      S_CFG_WIN: begin
        state_d = S_CFG_FRAME;
        aluop_d = OP_SETFRAME;
        width_d = frame_w_q;
      end
      S_CFG_FRAME: begin
        state_d    = S_RUN;
        aluop_d    = OP_SAD;
        col_d      = 32'd0;
        row_d      = 32'd0;
        mem_addr_d = frame_base_q;
        win_addr_d = window_base_q;
      end
      S_RUN: begin
        if (!hold) begin
          if (last_col && last_row) begin
            state_d = S_DONE;
            aluop_d = OP_IDLE;
            sadop_d = 1'b0;
            done_d  = 1'b1;
          end else if (last_col) begin
            // Row wrap: frame jumps to next row start, window is contiguous.
            col_d      = 32'd0;
            row_d      = row_q + 32'd1;
            mem_addr_d = mem_addr_q + row_jump;
            win_addr_d = win_addr_q + ADDR_STEP;
          end else begin
            col_d      = col_q + 32'd1;
            mem_addr_d = mem_addr_q + ADDR_STEP;
            win_addr_d = win_addr_q + ADDR_STEP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        aluop_d = OP_IDLE;
        sadop_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        aluop_d = OP_IDLE;
        sadop_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      win_w_q       <= '0;
      win_h_q       <= '0;
      frame_w_q     <= '0;
      frame_base_q  <= '0;
      window_base_q <= '0;
      col_q         <= '0;
      row_q         <= '0;
      mem_addr_q    <= '0;
      win_addr_q    <= '0;
      width_q       <= '0;
      height_q      <= '0;
      aluop_q       <= OP_IDLE;
      sadop_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_w_q       <= win_w_d;
      win_h_q       <= win_h_d;
      frame_w_q     <= frame_w_d;
      frame_base_q  <= frame_base_d;
      window_base_q <= window_base_d;
      col_q         <= col_d;
      row_q         <= row_d;
      mem_addr_q    <= mem_addr_d;
      win_addr_q    <= win_addr_d;
      width_q       <= width_d;
      height_q      <= height_d;
      aluop_q       <= aluop_d;
      sadop_q       <= sadop_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cmd.MemAddress    = mem_addr_q;
  assign cmd.WindowAddress = win_addr_q;
  assign cmd.Width         = width_q;
  assign cmd.Height        = height_q;
  assign cmd.ALUOp         = aluop_q;
  assign cmd.SADOp         = sadop_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_sad_sequencer.sv
// Bench for sad_sequencer: cycle-by-cycle expected bus states are queued when a
// pass is launched and compared on the falling edge as the pass unfolds.
module tb_sad_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, start, hold;
  logic [31:0] frame_base, window_base, win_w, win_h, frame_w;
  logic        busy, done, err;

  sad_sequencer_if bus();

  sad_sequencer dut (
    .Clk(Clk), .Rst(Rst), .start(start), .hold(hold),
    .frame_base(frame_base), .window_base(window_base),
    .win_w(win_w), .win_h(win_h), .frame_w(frame_w),
    .cmd(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] mem, win, wd, ht;
    logic        sad, bsy, dn, er;
  } rec_t;

  rec_t q[$];
  rec_t exp_prev;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic rec_t sample();
    rec_t r;
    r.op = bus.ALUOp; r.mem = bus.MemAddress; r.win = bus.WindowAddress;
    r.wd = bus.Width; r.ht = bus.Height; r.sad = bus.SADOp;
    r.bsy = busy; r.dn = done; r.er = err;
    return r;
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf("op=%b mem=%h win=%h w=%0d h=%0d sad=%b busy=%b done=%b err=%b",
                     r.op, r.mem, r.win, r.wd, r.ht, r.sad, r.bsy, r.dn, r.er);
  endfunction

  // Reference model: expected visible state after each edge from E0 on.
  task automatic push_pass(input logic [31:0] fb, wb, w, h, fw,
                           input int hold_at, input int hold_n);
    rec_t r;
    int   idx = 0;
    r = exp_prev;
    r.dn = 1'b0; r.er = 1'b0;
    if (w == 0 || h == 0) begin
      r.op = 6'b000000; r.sad = 1'b0; r.bsy = 1'b1; r.dn = 1'b1; r.er = 1'b1;
      q.push_back(r);
    end else begin
      r.op = 6'b111110; r.wd = w; r.ht = h; r.sad = 1'b1; r.bsy = 1'b1;
      q.push_back(r);
      r.op = 6'b111100; r.wd = fw;
      q.push_back(r);
      r.op = 6'b111111;
      for (int rr = 0; rr < int'(h); rr++) begin
        for (int cc = 0; cc < int'(w); cc++) begin
          r.mem = fb + 32'd4 * (32'(rr) * fw + 32'(cc));
          r.win = wb + 32'd4 * (32'(rr) * w + 32'(cc));
          q.push_back(r);
          if (idx == hold_at) repeat (hold_n) q.push_back(r);
          idx++;
        end
      end
      r.op = 6'b000000; r.sad = 1'b0; r.dn = 1'b1;
      q.push_back(r);
    end
    r.dn = 1'b0; r.er = 1'b0; r.bsy = 1'b0;
    q.push_back(r);
    exp_prev = r;
  endtask

  task automatic set_args(input logic [31:0] fb, wb, w, h, fw);
    frame_base = fb; window_base = wb; win_w = w; win_h = h; frame_w = fw;
  endtask

  task automatic test_reset();
    rec_t a, e;
    Rst = 1'b1; start = 1'b1; hold = 1'b1;
    set_args(32'h10, 32'h20, 32'd2, 32'd2, 32'd4);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    e = '0; a = sample();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset: got %s, expected %s", fmt(a), fmt(e));
    end
    exp_prev = '0;
    Rst = 1'b0; start = 1'b0; hold = 1'b0;
  endtask

  // 2x2 basic pass; a stray start and changed inputs mid-pass must be ignored.
  task automatic test_basic();
    rec_t a, e;
    int   j = 0;
    set_args(32'h0, 32'h100, 32'd2, 32'd2, 32'd4);
    start = 1'b1;
    push_pass(32'h0, 32'h100, 32'd2, 32'd2, 32'd4, -1, 0);
    @(posedge Clk);
    while (q.size() > 0) begin
      @(negedge Clk);
      start = (j == 2);
      if (j == 2) set_args(32'h5000, 32'h7000, 32'd7, 32'd9, 32'd3);
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      j++;
    end
    start = 1'b0;
  endtask

  task automatic test_hold();
    rec_t a, e;
    int   j = 0;
    set_args(32'h0, 32'h100, 32'd2, 32'd2, 32'd4);
    start = 1'b1; hold = 1'b1;  // hold outside RUN has no effect
    push_pass(32'h0, 32'h100, 32'd2, 32'd2, 32'd4, 2, 2);
    @(posedge Clk);
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      hold  = (j == 0) || (j >= 4 && j < 6);
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL hold cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      j++;
    end
    hold = 1'b0;
  endtask

  task automatic test_zero();
    rec_t a, e;
    int   j = 0;
    set_args(32'h40, 32'h80, 32'd0, 32'd3, 32'd4);
    start = 1'b1;
    push_pass(32'h40, 32'h80, 32'd0, 32'd3, 32'd4, -1, 0);
    @(posedge Clk);
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL zero cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      j++;
    end
  endtask

  // Reset during the second beat, then an immediate restart of the same pass.
  task automatic test_reset_mid();
    rec_t a, e;
    int   j = 0;
    set_args(32'h0, 32'h100, 32'd2, 32'd2, 32'd4);
    start = 1'b1;
    push_pass(32'h0, 32'h100, 32'd2, 32'd2, 32'd4, -1, 0);
    @(posedge Clk);
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rstmid cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      if (j == 3) begin
        Rst = 1'b1;
        q.delete();
      end
      j++;
    end
    @(negedge Clk);
    e = '0; a = sample();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL rstmid zeros: got %s, expected %s", fmt(a), fmt(e));
    end
    exp_prev = '0;
    Rst = 1'b0; start = 1'b1;
    push_pass(32'h0, 32'h100, 32'd2, 32'd2, 32'd4, -1, 0);
    @(posedge Clk);
    j = 0;
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL restart cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      j++;
    end
  endtask

  // Address wrap pass followed by a start issued in the first idle cycle.
  task automatic test_back_to_back();
    rec_t a, e;
    int   j = 0;
    set_args(32'hFFFFFFF8, 32'h200, 32'd3, 32'd1, 32'd8);
    start = 1'b1;
    push_pass(32'hFFFFFFF8, 32'h200, 32'd3, 32'd1, 32'd8, -1, 0);
    @(posedge Clk);
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL wrap cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      if (q.size() == 0) begin
        set_args(32'h40, 32'h80, 32'd1, 32'd2, 32'd5);
        start = 1'b1;
      end
      j++;
    end
    push_pass(32'h40, 32'h80, 32'd1, 32'd2, 32'd5, -1, 0);
    @(posedge Clk);
    j = 0;
    while (q.size() > 0) begin
      @(negedge Clk);
      start = 1'b0;
      e = q.pop_front(); a = sample();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %s, expected %s", j, fmt(a), fmt(e));
      end
      j++;
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; hold = 1'b0;
    set_args('0, '0, '0, '0, '0);
    exp_prev = '0;
    test_reset();
    test_basic();
    test_hold();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
